// File: rtl/serial_adder_seq.sv
// ============================================================================
// Module   : serial_adder_seq
// Purpose  : Bit-serial adder sequencer; feeds an external 1-bit full-adder
//            cell LSB first and assembles the sum and carry-out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin_in,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_carry,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout
);

   localparam int                C_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_a_sr;
   logic [WIDTH-1:0]   r_b_sr;
   logic               r_c;
   logic [C_CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0]   r_result;
   logic               r_cout;
   logic               w_run;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (r_cnt == C_LAST) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sr   <= '0;
         r_b_sr   <= '0;
         r_c      <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a_sr <= op_a;
                  r_b_sr <= op_b;
                  r_c    <= cin_in;
                  r_cnt  <= '0;
               end
            end
            S_RUN: begin
               // Sum bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
               r_result <= {fa_sum, r_result[WIDTH-1:1]};
               r_c      <= fa_carry;
               r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
               r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
               r_cnt    <= r_cnt + C_CNT_W'(1);
               if (r_cnt == C_LAST) begin
                  r_cout <= fa_carry;
               end
            end
            default: ;
         endcase
      end
   end

   // Cell drive is gated by registered state only: no path from start/op_*.
   assign w_run  = (r_state == S_RUN);
   assign fa_a   = w_run & r_a_sr[0];
   assign fa_b   = w_run & r_b_sr[0];
   assign fa_cin = w_run & r_c;

   assign busy   = (r_state != S_IDLE);
   assign done   = (r_state == S_DONE);
   assign result = r_result;
   assign cout   = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_seq.sv
// ============================================================================
// Module   : tb_serial_adder_seq
// Purpose  : Randomized self-checking bench for serial_adder_seq with an
//            arithmetic reference model and a behavioural full-adder cell.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_seq;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             cin_in;
   logic             fa_a;
   logic             fa_b;
   logic             fa_cin;
   logic             fa_sum;
   logic             fa_carry;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;

   int n_checks = 0;
   int n_errors = 0;

   serial_adder_seq #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op_a     (op_a),
      .op_b     (op_b),
      .cin_in   (cin_in),
      .fa_a     (fa_a),
      .fa_b     (fa_b),
      .fa_cin   (fa_cin),
      .fa_sum   (fa_sum),
      .fa_carry (fa_carry),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout)
   );

   // Behavioural full-adder cell.
   assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
   assign fa_carry = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Carry entering bit i of a+b+c, from plain integer arithmetic.
   function automatic logic carry_into(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic c, input int i);
      int m;
      int s;
      m = (1 << i) - 1;
      s = ((int'(a) & m) + (int'(b) & m) + int'(c)) >> i;
      return s[0];
   endfunction

   // Called at a negedge; returns at the negedge after the DONE cycle (state IDLE).
   task automatic do_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                         input bit hold, input bit inject);
      logic [WIDTH:0] exp_sum;
      exp_sum = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(c);
      start  = 1'b1;
      op_a   = a;
      op_b   = b;
      cin_in = c;
      @(posedge clk);
      for (int i = 0; i < WIDTH; i++) begin
         @(negedge clk);
         if (!hold && i == 0) start = 1'b0;
         if (inject && i == 3) begin
            start = 1'b1;
            op_a  = 8'h11;
            op_b  = 8'h22;
         end
         if (inject && i == 4) start = 1'b0;
         check("run_busy", 32'(busy), 32'd1);
         check("run_done", 32'(done), 32'd0);
         check("fa_a", 32'(fa_a), 32'(a[i]));
         check("fa_b", 32'(fa_b), 32'(b[i]));
         check("fa_cin", 32'(fa_cin), 32'(carry_into(a, b, c, i)));
      end
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd1);
      check("result", 32'(result), 32'(exp_sum[WIDTH-1:0]));
      check("cout", 32'(cout), 32'(exp_sum[WIDTH]));
      check("done_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("hold_result", 32'(result), 32'(exp_sum[WIDTH-1:0]));
      check("hold_cout", 32'(cout), 32'(exp_sum[WIDTH]));
      check("idle_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
   endtask

   // Starts an addition and asserts reset between edges after the 4th RUN edge.
   task automatic abort_run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
      start  = 1'b1;
      op_a   = a;
      op_b   = b;
      cin_in = c;
      @(posedge clk);
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         if (i == 0) start = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      op_a   = '0;
      op_b   = '0;
      cin_in = 1'b0;
      #12;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_result", 32'(result), 32'd0);
      check("reset_cout", 32'(cout), 32'd0);
      check("reset_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_add(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
      do_add(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      do_add(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
      do_add(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);

      abort_run(8'hFF, 8'hFF, 1'b1);
      check("post_rst_busy", 32'(busy), 32'd0);
      do_add(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

      // Back-to-back: start held high, new operands at every accepting edge.
      for (int k = 0; k < 5; k++) begin
         do_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1, 1'b0);
      end

      for (int k = 0; k < 15; k++) begin
         do_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                bit'($urandom_range(0, 1)), 1'b0);
      end

      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("final_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
- Bit-serial adder sequencer that drives the team's 1-bit full-adder cell and consumes its outputs.
- Loads two WIDTH-bit operands and a carry-in on a start request.
- Presents one operand bit pair plus the stored carry to the cell per clock, LSB first.
- Assembles the sum bits into a result register, then reports done with a carry-out.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin an addition; sampled only in IDLE
- op_a  input  WIDTH  operand A, captured on the accepted start edge
- op_b  input  WIDTH  operand B, captured on the accepted start edge
- cin_in  input  1  initial carry-in, captured on the accepted start edge
- fa_a  output  1  bit of A presented to the full-adder cell
- fa_b  output  1  bit of B presented to the full-adder cell
- fa_cin  output  1  stored carry presented to the full-adder cell
- fa_sum  input  1  sum returned by the full-adder cell (combinational from fa_*)
- fa_carry  input  1  carry returned by the full-adder cell
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse: result and cout are final
- result  output  WIDTH  sum of the operands
- cout  output  1  final carry-out

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - Shift registers, carry register, bit counter, result and cout all clear to 0.
  - busy, done and fa_a/fa_b/fa_cin are 0.
  - Reset takes effect immediately, including mid-operation; no partial result survives.
- State machine:
  - IDLE -> RUN on a clock edge where start=1. On that edge, A_sr<=op_a, B_sr<=op_b, c_reg<=cin_in, cnt<=0.
  - RUN, every edge:
    - result <= {fa_sum, result[WIDTH-1:1]}; c_reg <= fa_carry.
    - A_sr and B_sr shift right by 1; cnt++.
    - When cnt==WIDTH-1 on that edge: cout <= fa_carry and the state goes to DONE.
  - DONE -> IDLE unconditionally on the next edge.
- Cell drive:
  - In RUN, fa_a=A_sr[0], fa_b=B_sr[0], fa_cin=c_reg. All are driven from registers only, so there is no combinational path from the start/op_* inputs.
  - In IDLE and DONE, fa_a, fa_b and fa_cin are 0.
- Latency:
  - The start edge is E0. RUN covers edges E1..EWIDTH.
  - done is high for exactly the one cycle following edge EWIDTH. For WIDTH=8, done rises 8 edges after the start edge.
  - Throughput is one addition per WIDTH+2 cycles.
- busy = (state != IDLE).
- Start handling:
  - start is ignored while busy (RUN or DONE); no queuing.
  - start held high continuously produces back-to-back additions: each new start is accepted on the first IDLE edge, with op_* re-sampled at that edge.
- Result validity:
  - result and cout are valid when done=1.
  - They hold their values until the next accepted start. During RUN, result holds partial shifted data and must not be used.
- Arithmetic:
  - {cout, result} = op_a + op_b + cin_in, taken modulo 2^(WIDTH+1).
  - No signed interpretation; the overflow indication is cout only.
- Counter: cnt is $clog2(WIDTH) bits wide. It does not wrap, because the state leaves RUN at WIDTH-1.

Test Plan:
- WIDTH=8; op_a=8'h5A, op_b=8'h3C, cin_in=0, start for 1 cycle -> busy rises after E0; done pulses 1 cycle after E8; result=8'h96, cout=0.
- op_a=8'hFF, op_b=8'h01, cin_in=0 -> result=8'h00, cout=1. Then op_a=8'hFF, op_b=8'hFF, cin_in=1 -> result=8'hFF, cout=1.
- During RUN, pulse start with new operands 8'h11/8'h22 -> ignored. The first addition completes unchanged; busy stays high, with no extra done pulse.
- Assert rst_n=0 between edges at E4 of an addition -> state, result, cout, busy and fa_* go to 0 immediately without a clock. After release, a fresh 8'h01+8'h01 gives 8'h02, cout=0.
- Hold start=1 continuously with operands changed each operation -> done pulses every 10 cycles, each with the correct sum of the operands present at its accepting IDLE edge.
- In RUN, check cycle by cycle that fa_a/fa_b equal op bits LSB-first and fa_cin equals the previous fa_carry; fa_* are 0 in IDLE and DONE.
